// File: rtl/dmem_responder.sv
// Data-memory responder: single-outstanding load/store slave with a fixed
// access latency, byte/half/word lanes on a word array, one-cycle response.
//
// state  | meaning
// S_IDLE | no access in flight, ready for a request
// S_WAIT | accepted access counting down its latency, pipeline stalled
// S_RESP | response pulse cycle, ready for a back-to-back request
module dmem_responder #(
   parameter int DEPTH_WORDS = 1024,
   parameter int LATENCY     = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   input  logic        req_we,
   input  logic [1:0]  req_size,
   input  logic        req_signed,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        req_ready,
   output logic        resp_valid,
   output logic [31:0] resp_rdata,
   output logic        resp_err,
   output logic        stall
);

   localparam int AW = $clog2(DEPTH_WORDS);
   localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WAIT = 2'd1,
      S_RESP = 2'd2
   } state_t;

   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          we_q, we_d;
   logic [1:0]    size_q, size_d;
   logic          sgn_q, sgn_d;
   logic [AW+1:0] addr_q, addr_d;
   logic [31:0]   wdata_q, wdata_d;
   logic [31:0]   rdata_q, rdata_d;
   logic          err_q, err_d;

   logic [31:0]   mem_q [DEPTH_WORDS];

   logic          req_bad;
   logic          access_fire;
   logic [31:0]   word_rd;
   logic [31:0]   lane_rd;
   logic [31:0]   load_data;
   logic [3:0]    byte_en;
   logic [31:0]   wdata_lanes;

   // Address bits above the array are deliberately ignored (aliasing wrap).
   logic unused_addr_hi;
   assign unused_addr_hi = ^req_addr[31:AW+2];

   always_comb begin
      req_bad = 1'b0;
      case (req_size)
         2'b00:   req_bad = 1'b0;
         2'b01:   req_bad = req_addr[0];
         2'b10:   req_bad = |req_addr[1:0];
         default: req_bad = 1'b1;
      endcase
   end

   assign access_fire = (state_q == S_WAIT) && (cnt_q == '0);

   // Only aligned accesses reach the array, so one shift serves both byte and half lanes.
   assign word_rd     = mem_q[addr_q[AW+1:2]];
   assign lane_rd     = word_rd >> {addr_q[1:0], 3'b000};
   assign wdata_lanes = wdata_q << {addr_q[1:0], 3'b000};

   always_comb begin
      load_data = word_rd;
      byte_en   = 4'b1111;
      case (size_q)
         2'b00: begin
            load_data = {{24{sgn_q & lane_rd[7]}}, lane_rd[7:0]};
            byte_en   = 4'b0001 << addr_q[1:0];
         end
         2'b01: begin
            load_data = {{16{sgn_q & lane_rd[15]}}, lane_rd[15:0]};
            byte_en   = 4'b0011 << addr_q[1:0];
         end
         default: begin
            load_data = word_rd;
            byte_en   = 4'b1111;
         end
      endcase
   end

   // A store still waiting when reset arrives is dropped.
   always_ff @(posedge clk) begin
      if (rst && access_fire && we_q) begin
         for (int b = 0; b < 4; b++) begin
            if (byte_en[b]) begin
               mem_q[addr_q[AW+1:2]][8*b +: 8] <= wdata_lanes[8*b +: 8];
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         we_q    <= 1'b0;
         size_q  <= 2'b00;
         sgn_q   <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         we_q    <= we_d;
         size_q  <= size_d;
         sgn_q   <= sgn_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
         err_q   <= err_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      we_d      = we_q;
      size_d    = size_q;
      sgn_d     = sgn_q;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      rdata_d   = '0;
      err_d     = 1'b0;
      req_ready = 1'b0;
      stall     = 1'b0;
      case (state_q)
         S_IDLE, S_RESP: begin
            req_ready = 1'b1;
            state_d   = S_IDLE;
            if (req_valid) begin
               we_d    = req_we;
               size_d  = req_size;
               sgn_d   = req_signed;
               addr_d  = req_addr[AW+1:0];
               wdata_d = req_wdata;
               if (req_bad) begin
                  state_d = S_RESP;
                  err_d   = 1'b1;
               end else begin
                  cnt_d   = CW'(LATENCY - 1);
                  state_d = S_WAIT;
               end
            end
         end
         S_WAIT: begin
            stall = 1'b1;
            if (cnt_q == '0) begin
               state_d = S_RESP;
               rdata_d = we_q ? 32'h0 : load_data;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign resp_valid = (state_q == S_RESP);
   assign resp_rdata = rdata_q;
   assign resp_err   = err_q;

endmodule
